// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: grants one of MASTER_NUM AXI masters the shared address
// path and holds the grant until the granted master's final response beat
// completes. The policy is round-robin (RR_MODE=1) or fixed priority with
// index 0 highest (RR_MODE=0).
//
//   state | meaning
//   IDLE  | no master holds the bus, sel = 0
//   BUSY  | one master holds the bus, sel one-hot until its last beat
module axi_rr_arbiter #(
    parameter int MASTER_NUM = 2,
    parameter int RR_MODE    = 1,
    parameter int ID_W       = (MASTER_NUM > 2) ? $clog2(MASTER_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MASTER_NUM-1:0] avalid,
    input  logic [MASTER_NUM-1:0] resp_valid,
    input  logic [MASTER_NUM-1:0] resp_ready,
    input  logic [MASTER_NUM-1:0] resp_last,
    output logic [MASTER_NUM-1:0] sel,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [MASTER_NUM-1:0]   sel_nxt;
    logic [ID_W-1:0]         grant_id_nxt;
    logic [ID_W-1:0]         ptr, ptr_nxt;
    logic [ID_W-1:0]         win_idx;
    logic [ID_W-1:0]         cand_idx;
    logic                    win_found;
    logic                    done;
    int                      cand;

    // Only the granted master's final completed beat ends a transaction.
    assign done = |(sel & resp_valid & resp_ready & resp_last);
    assign busy = |sel;

    // Winner search: from ptr with wrap in round-robin mode, from 0 in fixed mode.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (RR_MODE != 0) begin
                cand = int'(ptr) + i;
                if (cand >= MASTER_NUM) cand = cand - MASTER_NUM;
            end else begin
                cand = i;
            end
            cand_idx = ID_W'(cand);
            if (!win_found && avalid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-grant logic; a new grant may replace a finishing one directly.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        grant_id_nxt = grant_id;
        ptr_nxt      = ptr;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt    = BUSY;
                    sel_nxt      = MASTER_NUM'(1) << win_idx;
                    grant_id_nxt = win_idx;
                end
            end
            BUSY: begin
                if (done) begin
                    if (win_found) begin
                        sel_nxt      = MASTER_NUM'(1) << win_idx;
                        grant_id_nxt = win_idx;
                    end else begin
                        state_nxt    = IDLE;
                        sel_nxt      = '0;
                        grant_id_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                sel_nxt      = '0;
                grant_id_nxt = '0;
            end
        endcase
        // The pointer moves past every newly granted master.
        if ((RR_MODE != 0) && win_found && ((state == IDLE) || done)) begin
            if (int'(win_idx) == MASTER_NUM - 1) ptr_nxt = '0;
            else                                 ptr_nxt = win_idx + 1'b1;
        end
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            grant_id <= grant_id_nxt;
            ptr      <= ptr_nxt;
        end
    end

endmodule
